// File: rtl/booth_mult_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one iteration per clock,
// product held until the next completing edge, done/ack handshake.
module booth_mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               ack,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // Extra accumulator bit keeps -2^(WIDTH-1) multiplicands exact.
  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {op_a[WIDTH-1], op_a};
          q_d     = op_b;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          prod_d  = {a_d[WIDTH-1:0], q_d};
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq_ctrl.sv
// Bench for booth_mult_seq_ctrl: WIDTH=8 and WIDTH=4 instances,
// each compared every cycle against a transaction-level model.
module tb_booth_mult_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        rst8 = 1'b0, start8 = 1'b0, ack8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, busy8, done8;
  logic [15:0] prod8;

  logic        rst4 = 1'b0, start4 = 1'b0, ack4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, busy4, done4;
  logic [7:0]  prod4;

  booth_mult_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8),
    .op_a(a8), .op_b(b8), .ack(ack8),
    .ready(ready8), .busy(busy8), .done(done8),
    .product(prod8)
  );

  booth_mult_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4),
    .op_a(a4), .op_b(b4), .ack(ack4),
    .ready(ready4), .busy(busy4), .done(done4),
    .product(prod4)
  );

  function automatic logic [15:0] mul8(logic [7:0] a, logic [7:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    return 16'(ia * ib);
  endfunction

  function automatic logic [7:0] mul4(logic [3:0] a, logic [3:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    return 8'(ia * ib);
  endfunction

  // Model: mode 0 idle, 1 computing, 2 result shown.
  int          m8_mode = 0, m8_left = 0;
  logic [15:0] m8_prod = '0, m8_res = '0;
  int          m4_mode = 0, m4_left = 0;
  logic [7:0]  m4_prod = '0, m4_res = '0;

  always @(posedge clk or negedge rst8) begin
    if (!rst8) begin
      m8_mode <= 0; m8_left <= 0;
      m8_prod <= '0; m8_res <= '0;
    end else begin
      case (m8_mode)
        0: if (start8) begin
          m8_mode <= 1; m8_left <= 8;
          m8_res  <= mul8(a8, b8);
        end
        1: if (m8_left == 1) begin
          m8_mode <= 2; m8_prod <= m8_res;
        end else m8_left <= m8_left - 1;
        2: if (ack8) m8_mode <= 0;
        default: m8_mode <= 0;
      endcase
    end
  end

  always @(posedge clk or negedge rst4) begin
    if (!rst4) begin
      m4_mode <= 0; m4_left <= 0;
      m4_prod <= '0; m4_res <= '0;
    end else begin
      case (m4_mode)
        0: if (start4) begin
          m4_mode <= 1; m4_left <= 4;
          m4_res  <= mul4(a4, b4);
        end
        1: if (m4_left == 1) begin
          m4_mode <= 2; m4_prod <= m4_res;
        end else m4_left <= m4_left - 1;
        2: if (ack4) m4_mode <= 0;
        default: m4_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({ready8, busy8, done8, prod8} !==
        {m8_mode == 0, m8_mode == 1, m8_mode == 2, m8_prod}) begin
      failures++;
      $display("FAIL cyc8 t=%0t got r/b/d=%b%b%b p=%h want %b%b%b p=%h",
               $time, ready8, busy8, done8, prod8,
               m8_mode == 0, m8_mode == 1, m8_mode == 2, m8_prod);
    end
    checks++;
    if ({ready4, busy4, done4, prod4} !==
        {m4_mode == 0, m4_mode == 1, m4_mode == 2, m4_prod}) begin
      failures++;
      $display("FAIL cyc4 t=%0t got r/b/d=%b%b%b p=%h want %b%b%b p=%h",
               $time, ready4, busy4, done4, prod4,
               m4_mode == 0, m4_mode == 1, m4_mode == 2, m4_prod);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] ev, input string nm);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, 8);
    chk({nm, "_prod"}, prod8, ev);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] ev, input string nm);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    n = 0;
    while (!done4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, 4);
    chk({nm, "_prod"}, prod4, ev);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ack4 = 1'b1;
    @(negedge clk);
    ack4 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  ra, rb;
    logic [3:0]  sa, sb;
    logic [15:0] p;
    int n;

    repeat (2) @(negedge clk);
    chk("rst_ready", ready8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_prod", prod8, 0);
    rst8 = 1'b1;
    rst4 = 1'b1;

    run8(8'd3, 8'd5, 16'h000F, "3x5");
    run8(8'hF9, 8'd3, 16'hFFEB, "m7x3");
    run8(8'd3, 8'hF9, 16'hFFEB, "3xm7");
    run8(8'hFF, 8'hFF, 16'h0001, "m1xm1");
    run8(8'd0, 8'h80, 16'h0000, "0xm128");
    run8(8'h80, 8'h80, 16'h4000, "m128sq");
    run8(8'h80, 8'h7F, 16'hC080, "m128x127");
    run8(8'h7F, 8'h7F, 16'h3F01, "127sq");

    // Operand and start noise during CALC with ack held high.
    @(negedge clk);
    a8 = 8'hF9; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; ack8 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("noise_busy", busy8, 1);
      a8 = 8'($urandom); b8 = 8'($urandom);
      start8 = 1'($urandom);
    end
    @(negedge clk);
    start8 = 1'b0;
    chk("noise_done", done8, 1);
    chk("noise_prod", prod8, 16'hFFB3);
    @(negedge clk);
    ack8 = 1'b0;
    chk("noise_idle", ready8, 1);

    // Long DONE dwell, then start+ack together.
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (8) @(negedge clk);
    p = prod8;
    repeat (20) begin
      @(negedge clk);
      chk("dwell_done", done8, 1);
    end
    chk("dwell_prod", prod8, p);
    a8 = 8'd6; b8 = 8'd7;
    start8 = 1'b1; ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    chk("sa_idle", ready8, 1);
    @(negedge clk);
    start8 = 1'b0;
    chk("sa_accept", busy8, 1);
    repeat (8) @(negedge clk);
    chk("sa_prod", prod8, 16'd42);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;

    // Back-to-back throughput with start and ack held high.
    a8 = 8'd9; b8 = 8'hFE; start8 = 1'b1; ack8 = 1'b1;
    n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    @(negedge clk);
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    chk("b2b_period", n + 1, 10);
    chk("b2b_prod", prod8, 16'hFFEE);
    start8 = 1'b0;
    @(negedge clk);
    ack8 = 1'b0;
    @(negedge clk);

    // Reset in the middle of CALC.
    a8 = 8'd5; b8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst8 = 1'b0;
    #1;
    chk("mid_rst_ready", ready8, 1);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_prod", prod8, 0);
    @(negedge clk);
    chk("mid_rst_hold", done8, 0);
    rst8 = 1'b1;
    run8(8'd2, 8'd2, 16'h0004, "2x2");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      run8(ra, rb, mul8(ra, rb), "rnd8");
    end
    run4(4'h8, 4'h8, 8'h40, "m8sq");
    run4(4'h8, 4'h7, 8'hC8, "m8x7");
    for (int i = 0; i < 1000; i++) begin
      sa = 4'($urandom); sb = 4'($urandom);
      run4(sa, sb, mul4(sa, sb), "rnd4");
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
